// File: rtl/csa_mult_pkg.sv
// Shared definitions for the carry-save sequential multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package csa_mult_pkg;

  localparam int W = 32;

  // Index of the final ACCUM cycle; 32 partial products, counted 0..31.
  localparam int ACCUM_LAST = 31;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    RESOLVE  = 3'd2,
    RESOLVE2 = 3'd3,
    DONE     = 3'd4
  } csa_mult_state_t;

endpackage

// File: rtl/csa.sv
// 32-bit 3:2 carry-save adder: reduces three operands to a sum/carry pair.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y, z operands; sum = bitwise sum; carry = majority shifted left
// by one (bit 0 is zero, the carry out of bit W-1 is dropped).
module csa
  import csa_mult_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = x ^ y ^ z;
  assign maj   = (x & y) | (x & z) | (y & z);
  assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_seq_mult.sv
// Sequential 32x32 -> low 32-bit multiplier, running product kept in carry-save form.
// Latency: 33 cycles from acceptance to out_valid (34 with CSA_MULT_CPA_REG_EN).
// Backpressure: holds p/out_valid in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low); a, b, in_valid, in_ready (operand
// handshake); p, out_valid, out_ready (result handshake).
// Option: CSA_MULT_CPA_REG_EN registers sum/carry before the final add.
module csa_seq_mult
  import csa_mult_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] p,
  output logic         out_valid,
  input  logic         out_ready
);

  csa_mult_state_t state, state_nxt;

  logic [W-1:0] a_sh, b_sh;
  logic [W-1:0] sum_r, car_r;
  logic [W-1:0] pp, sum_nxt, car_nxt;
  logic [4:0]   cnt;

`ifdef CSA_MULT_CPA_REG_EN
  logic [W-1:0] s_q, c_q;
`endif

  // One partial product per cycle: multiplier bit 0 selects the shifted multiplicand.
  assign pp = b_sh[0] ? a_sh : '0;

  csa u_csa (
    .x     (sum_r),
    .y     (car_r),
    .z     (pp),
    .sum   (sum_nxt),
    .carry (car_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = ACCUM;
      ACCUM:    if (cnt == 5'(ACCUM_LAST)) state_nxt = RESOLVE;
`ifdef CSA_MULT_CPA_REG_EN
      RESOLVE:  state_nxt = RESOLVE2;
      RESOLVE2: state_nxt = DONE;
`else
      RESOLVE:  state_nxt = DONE;
`endif
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready = 1'b0;
    if (state == IDLE) in_ready = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_r     <= '0;
      car_r     <= '0;
      cnt       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
`ifdef CSA_MULT_CPA_REG_EN
      s_q       <= '0;
      c_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            sum_r <= '0;
            car_r <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          sum_r <= sum_nxt;
          car_r <= car_nxt;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 5'd1;
        end
`ifdef CSA_MULT_CPA_REG_EN
        RESOLVE: begin
          // Register the carry-save pair so the ripple add starts from flops.
          s_q <= sum_r;
          c_q <= car_r;
        end
        RESOLVE2: begin
          p         <= s_q + c_q;
          out_valid <= 1'b1;
        end
`else
        RESOLVE: begin
          p         <= sum_r + car_r;
          out_valid <= 1'b1;
        end
`endif
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_mult.sv
module tb_csa_seq_mult;

`ifdef CSA_MULT_CPA_REG_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p;
  logic        out_valid;
  logic        out_ready;

  int total  = 0;
  int passes = 0;

  csa_seq_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: low 32 bits of the full 64-bit product.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] full;
    full = {32'd0, x} * {32'd0, y};
    return full[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Present one operand pair in IDLE, measure latency, check product and handshake.
  task automatic run_one(input logic [31:0] aa, input logic [31:0] bb, input string tag);
    int k;
    @(negedge clk);
    a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(LAT));
    check({tag, "_p"}, p, ref_mul(aa, bb));
    @(posedge clk); #1;
    check({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_inready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held, exp1, exp2, a1, b1, a2, b2;
    logic        seen;
    bit          got1;
    int          k, acc2;
    logic        prev_rdy;

    rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_p", p, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed products; out_ready is already high before out_valid.
    run_one(32'd3, 32'd5, "small");
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap_ones");
    run_one(32'h0001_0000, 32'h0001_0000, "wrap_zero");
    run_one(32'h0000_FFFF, 32'h0000_FFFF, "carry_prop");
    run_one(32'h8000_0000, 32'd1, "msb");
    run_one(32'd0, 32'hDEAD_BEEF, "zero_a");

    for (int i = 0; i < 16; i++) begin
      run_one($urandom, $urandom, "rand");
    end

    // Backpressure: consumer stalls 10 cycles, in_valid pulses must be ignored.
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF1; in_valid = 1'b1;
    exp1 = ref_mul(32'h1234_5678, 32'h9ABC_DEF1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_latency", 32'(k), 32'(LAT));
    check("bp_p", p, exp1);
    held = p;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("bp_p_hold", p, exp1);
      check("bp_ovalid_hold", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ovalid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    run_one(32'd11, 32'd13, "after_bp");

    // Reset in the middle of ACCUM.
    @(negedge clk);
    a = 32'hDEAD_0001; b = 32'hBEEF_0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_p", p, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("midrst_no_result", {31'd0, seen}, 32'd0);
    run_one(32'd7, 32'd6, "post_rst");

    // Back-to-back: in_valid stays high across two operations.
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    exp1 = ref_mul(a1, b1);
    exp2 = ref_mul(a2, b2);
    @(negedge clk);
    a = a1; b = b1; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a = a2; b = b2;
    k = 0; got1 = 1'b0; acc2 = -1; prev_rdy = 1'b0;
    while (acc2 < 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (out_valid && !got1) begin
        got1 = 1'b1;
        check("b2b_first_latency", 32'(k), 32'(LAT));
        check("b2b_first_p", p, exp1);
      end
      if (prev_rdy && !in_ready) acc2 = k;
      prev_rdy = in_ready;
    end
    in_valid = 1'b0;
    check("b2b_first_seen", {31'd0, got1}, 32'd1);
    check("b2b_second_accept_edge", 32'(acc2), 32'(LAT + 2));
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("b2b_second_latency", 32'(k), 32'(LAT));
    check("b2b_second_p", p, exp2);
    @(posedge clk); #1;
    check("b2b_done_ovalid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
